// File: rtl/skid_fifo.sv
// Ready/valid FIFO with optional empty-bypass (fall-through) output, flush,
// and occupancy / stall statistics.
module skid_fifo #(
    parameter int W            = 8,
    parameter int DEPTH        = 4,
    parameter int FALL_THROUGH = 1,
    parameter int AFULL_TH     = DEPTH - 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [W-1:0]                 in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [W-1:0]                 out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         almost_full,
    output logic [$clog2(DEPTH+1)-1:0]   hwm,
    output logic [31:0]                  stall_cnt
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] next_count;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          bypass;
    logic          store;
    logic          take;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign in_ready = ~full & ~flush;

    // When empty in fall-through mode the upstream word is presented directly;
    // otherwise the head of storage is shown, so stored data is never overtaken.
    always_comb begin
        if ((FALL_THROUGH != 0) && empty) begin
            out_valid = in_valid & ~flush;
            out_data  = in_data;
        end else begin
            out_valid = ~empty & ~flush;
            out_data  = mem[rd_ptr];
        end
    end

    assign push   = in_valid & in_ready;
    assign pop    = out_valid & out_ready;
    assign bypass = (FALL_THROUGH != 0) & empty & push & pop;
    assign store  = push & ~bypass;
    assign take   = pop & ~bypass;

    always_comb begin
        next_count = count;
        if (flush) begin
            next_count = '0;
        end else if (store && !take) begin
            next_count = count + CW'(1);
        end else if (take && !store) begin
            next_count = count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            almost_full <= 1'b0;
            hwm         <= '0;
            stall_cnt   <= '0;
        end else begin
            count       <= next_count;
            almost_full <= (next_count >= CW'(AFULL_TH));
            if (next_count > hwm) begin
                hwm <= next_count;
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (store) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (take) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
            end
            if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    // Storage carries no reset; validity is tracked entirely by count/pointers.
    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_skid_fifo.sv
// Drives a registered-output and a fall-through skid_fifo side by side and
// compares both against queue-based reference models every cycle.
module tb_skid_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid [2];
    logic       out_ready [2];
    logic       flush [2];
    logic [7:0] in_data [2];
    logic       in_ready_o [2];
    logic       out_valid_o [2];
    logic       af_o [2];
    logic [7:0] out_data_o [2];
    logic [2:0] count_o [2];
    logic [2:0] hwm_o [2];
    logic [31:0] stall_o [2];

    int checks = 0;
    int errors = 0;

    logic [7:0]  q0 [$];
    logic [7:0]  q1 [$];
    logic [7:0]  got0 [$];
    logic [7:0]  got1 [$];
    int          hwm_m [2];
    logic [31:0] stall_m [2];
    bit          push_m [2];
    bit          pop_m [2];
    bit          ev_m [2];

    always #5 clk = ~clk;

    skid_fifo #(.W(8), .DEPTH(4), .FALL_THROUGH(0), .AFULL_TH(3)) u_ft0 (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready_o[0]),
        .out_data(out_data_o[0]), .out_valid(out_valid_o[0]), .out_ready(out_ready[0]),
        .flush(flush[0]), .count(count_o[0]), .almost_full(af_o[0]),
        .hwm(hwm_o[0]), .stall_cnt(stall_o[0])
    );

    skid_fifo #(.W(8), .DEPTH(4), .FALL_THROUGH(1), .AFULL_TH(3)) u_ft1 (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready_o[1]),
        .out_data(out_data_o[1]), .out_valid(out_valid_o[1]), .out_ready(out_ready[1]),
        .flush(flush[1]), .count(count_o[1]), .almost_full(af_o[1]),
        .hwm(hwm_o[1]), .stall_cnt(stall_o[1])
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic [7:0] d, input logic r, input logic f);
        for (int m = 0; m < 2; m++) begin
            in_valid[m]  = v;
            in_data[m]   = d;
            out_ready[m] = r;
            flush[m]     = f;
        end
    endtask

    // Expected outputs come from the stored-queue contents and the current inputs.
    task automatic model_compare(input int m);
        logic [7:0] q [$];
        int sz;
        bit ev, er;
        if (m == 0) q = q0; else q = q1;
        sz = q.size();
        er = (sz < 4) && !flush[m];
        ev = !flush[m] && ((sz > 0) || ((m == 1) && in_valid[m]));
        check_output($sformatf("in_ready%0d", m), 32'(in_ready_o[m]), 32'(er));
        check_output($sformatf("out_valid%0d", m), 32'(out_valid_o[m]), 32'(ev));
        if (ev) begin
            check_output($sformatf("out_data%0d", m), 32'(out_data_o[m]),
                         32'((sz > 0) ? q[0] : in_data[m]));
        end
        check_output($sformatf("count%0d", m), 32'(count_o[m]), 32'(sz));
        check_output($sformatf("almost_full%0d", m), 32'(af_o[m]), 32'(sz >= 3));
        check_output($sformatf("hwm%0d", m), 32'(hwm_o[m]), 32'(hwm_m[m]));
        check_output($sformatf("stall_cnt%0d", m), stall_o[m], stall_m[m]);
        push_m[m] = in_valid[m] && er;
        pop_m[m]  = ev && out_ready[m];
        ev_m[m]   = ev;
        if (ev && out_ready[m] && out_valid_o[m]) begin
            if (m == 0) got0.push_back(out_data_o[m]); else got1.push_back(out_data_o[m]);
        end
    endtask

    task automatic model_update(input int m);
        logic [7:0] q [$];
        int sz;
        if (m == 0) q = q0; else q = q1;
        sz = q.size();
        if (flush[m]) begin
            q.delete();
        end else begin
            if (pop_m[m] && sz > 0) void'(q.pop_front());
            if (push_m[m] && !(pop_m[m] && sz == 0)) q.push_back(in_data[m]);
        end
        if (q.size() > hwm_m[m]) hwm_m[m] = q.size();
        if (ev_m[m] && !out_ready[m] && stall_m[m] != 32'hFFFF_FFFF) stall_m[m] = stall_m[m] + 1;
        if (m == 0) q0 = q; else q1 = q;
    endtask

    task automatic step();
        @(negedge clk);
        model_compare(0);
        model_compare(1);
        @(posedge clk);
        model_update(0);
        model_update(1);
        #1;
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int m = 0; m < 2; m++) begin
            hwm_m[m]   = 0;
            stall_m[m] = 0;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 10; k++) begin
            if (q0.size() > 0 || q1.size() > 0) begin
                apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
                step();
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        for (int m = 0; m < 2; m++) begin
            check_output($sformatf("%s_count%0d", tag, m), 32'(count_o[m]), 32'd0);
            check_output($sformatf("%s_af%0d", tag, m), 32'(af_o[m]), 32'd0);
            check_output($sformatf("%s_hwm%0d", tag, m), 32'(hwm_o[m]), 32'd0);
            check_output($sformatf("%s_stall%0d", tag, m), stall_o[m], 32'd0);
            check_output($sformatf("%s_in_ready%0d", tag, m), 32'(in_ready_o[m]), 32'd1);
        end
        check_output({tag, "_out_valid0"}, 32'(out_valid_o[0]), 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        logic [7:0] words [10];
        int idx [2];
        rst_n = 1'b0;
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;
        step();

        // Zero-latency bypass into an empty fall-through FIFO.
        apply_stimulus(1'b1, 8'hA5, 1'b1, 1'b0);
        #1;
        check_output("bypass_valid", 32'(out_valid_o[1]), 32'd1);
        check_output("bypass_data", 32'(out_data_o[1]), 32'hA5);
        step();
        check_output("bypass_count", 32'(count_o[1]), 32'd0);
        drain();

        // Fill to capacity with the output stalled, then drain in order.
        for (int i = 1; i <= 5; i++) begin
            apply_stimulus(1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 5) begin
                #1;
                check_output("full_in_ready", 32'(in_ready_o[0]), 32'd0);
            end
            step();
        end
        check_output("full_count", 32'(count_o[0]), 32'd4);
        check_output("full_af", 32'(af_o[0]), 32'd1);
        check_output("full_hwm", 32'(hwm_o[0]), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
            #1;
            check_output($sformatf("drain_data%0d", i), 32'(out_data_o[0]), 32'(i));
            step();
        end
        drain();

        // Ten words streamed with out_ready toggling each cycle.
        for (int i = 0; i < 10; i++) words[i] = 8'($urandom);
        idx[0] = 0;
        idx[1] = 0;
        got0.delete();
        got1.delete();
        for (int cyc = 0; cyc < 80 && (got0.size() < 10 || got1.size() < 10); cyc++) begin
            for (int m = 0; m < 2; m++) begin
                in_valid[m]  = (idx[m] < 10);
                in_data[m]   = (idx[m] < 10) ? words[idx[m]] : 8'($urandom);
                out_ready[m] = cyc[0];
                flush[m]     = 1'b0;
            end
            step();
            for (int m = 0; m < 2; m++) if (push_m[m]) idx[m]++;
        end
        check_output("stream_len0", 32'(got0.size()), 32'd10);
        check_output("stream_len1", 32'(got1.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < got0.size()) check_output($sformatf("stream0_%0d", i), 32'(got0[i]), 32'(words[i]));
            if (i < got1.size()) check_output($sformatf("stream1_%0d", i), 32'(got1[i]), 32'(words[i]));
        end
        drain();

        // Flush with three stored and upstream still valid.
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
            step();
        end
        apply_stimulus(1'b1, 8'h99, 1'b0, 1'b1);
        #1;
        check_output("flush_in_ready0", 32'(in_ready_o[0]), 32'd0);
        check_output("flush_in_ready1", 32'(in_ready_o[1]), 32'd0);
        step();
        check_output("flush_count0", 32'(count_o[0]), 32'd0);
        check_output("flush_hwm0", 32'(hwm_o[0]), 32'd4);
        apply_stimulus(1'b1, 8'h77, 1'b0, 1'b0);
        step();
        check_output("after_flush0", 32'(out_data_o[0]), 32'h77);
        check_output("after_flush1", 32'(out_data_o[1]), 32'h77);

        // Five stall cycles, then saturation of the stall counter.
        begin
            logic [31:0] base;
            base = stall_m[0];
            for (int i = 0; i < 5; i++) begin
                apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
                step();
                check_output($sformatf("stall_hold%0d", i), 32'(out_data_o[0]), 32'h77);
            end
            check_output("stall_five", stall_o[0], base + 32'd5);
        end
        drain();
        force u_ft1.stall_cnt = 32'hFFFF_FFFE;
        stall_m[1] = 32'hFFFF_FFFE;
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
        step();
        release u_ft1.stall_cnt;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
            step();
        end
        check_output("stall_saturate", stall_o[1], 32'hFFFF_FFFF);
        drain();

        // Asynchronous reset with two entries stored, then random traffic.
        for (int i = 0; i < 2; i++) begin
            apply_stimulus(1'b1, 8'hE0 + 8'(i), 1'b0, 1'b0);
            step();
        end
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        for (int n = 0; n < 300; n++) begin
            for (int m = 0; m < 2; m++) begin
                in_valid[m]  = ($urandom_range(3) != 0);
                in_data[m]   = 8'($urandom);
                out_ready[m] = $urandom_range(1) != 0;
                flush[m]     = ($urandom_range(31) == 0);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/skid_fifo.md
SKID_FIFO -- requirements
Module: skid_fifo

Interface
REQ-001 SHALL have parameter W, default 8: data width in bits, 1..512.
REQ-002 SHALL have parameter DEPTH, default 4: storage entries; power of 2, ≥2.
REQ-003 SHALL have parameter FALL_THROUGH, default 1: 1 = empty-bypass mode, 0 = registered-output mode.
REQ-004 SHALL have parameter AFULL_TH, default DEPTH-1: almost_full threshold, 1..DEPTH.
REQ-005 SHALL have port clk, input, 1: sole clock; all state on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port in_data, input, W: upstream payload.
REQ-008 SHALL have port in_valid, input, 1: upstream valid.
REQ-009 SHALL have port in_ready, output, 1: upstream ready.
REQ-010 SHALL have port out_data, output, W: downstream payload.
REQ-011 SHALL have port out_valid, output, 1: downstream valid.
REQ-012 SHALL have port out_ready, input, 1: downstream ready.
REQ-013 SHALL have port flush, input, 1: synchronous discard of all stored entries.
REQ-014 SHALL have port count, output, $clog2(DEPTH+1): stored entries, registered.
REQ-015 SHALL have port almost_full, output, 1: registered, high when count ≥ AFULL_TH.
REQ-016 SHALL have port hwm, output, $clog2(DEPTH+1): maximum count observed since reset.
REQ-017 SHALL have port stall_cnt, output, 32: cycles with out_valid=1 and out_ready=0.

Function
REQ-018 SHALL store entries in a DEPTH-entry circular buffer with wrapping write/read pointers; push = in_valid & in_ready, pop = out_valid & out_ready.
REQ-019 SHALL drive in_ready = (count < DEPTH) & ~flush, with no combinational dependence on out_ready.
REQ-020 FALL_THROUGH=0: SHALL drive out_valid = (count ≠ 0) & ~flush and out_data = head entry; a push into an empty FIFO is visible at the output after 1 cycle.
REQ-021 FALL_THROUGH=1, count=0: SHALL drive out_valid = in_valid & ~flush and out_data = in_data (0-cycle latency); push with same-cycle pop SHALL bypass storage, leaving count and pointers unchanged.
REQ-022 FALL_THROUGH=1, count>0: SHALL behave as REQ-020; in_data SHALL never overtake stored entries (strict FIFO order).
REQ-023 Simultaneous push and pop with count>0 SHALL leave count unchanged and advance both pointers.
REQ-024 Full (count=DEPTH): in_ready=0; a pop that cycle SHALL not admit a push in the same cycle (in_ready rises the next cycle).
REQ-025 Empty with FALL_THROUGH=0: out_valid=0 irrespective of in_valid.
REQ-026 Pointer wrap from DEPTH-1 to 0 SHALL not alter order or count.
REQ-027 flush=1 SHALL block push and pop that cycle and SHALL set count, pointers to 0 at the next edge; stored data contents are don't-care.
REQ-028 While out_valid=1 and out_ready=0, out_data SHALL remain stable until the pop occurs (except on flush).
REQ-029 hwm SHALL update to next-count when next-count > hwm; SHALL not be cleared by flush.
REQ-030 stall_cnt SHALL increment by 1 per stall cycle and saturate at 0xFFFF_FFFF; SHALL not be cleared by flush.
REQ-031 Input violations (in_data change while in_valid=1 and in_ready=0) SHALL not corrupt stored entries.

Reset
REQ-032 On rst_n=0, asynchronously: count=0, pointers=0, almost_full=0, hwm=0, stall_cnt=0, out_valid=0 (FALL_THROUGH=0), in_ready=1 after reset release.
REQ-033 Reset asserted mid-operation SHALL discard all entries; first pop after release SHALL return only data pushed after release.
REQ-034 Storage array SHALL not require reset.

Verification
REQ-035 FALL_THROUGH=1, DEPTH=4, empty, out_ready=1, push 0xA5 -> out_valid=1 with out_data=0xA5 same cycle; count stays 0.
REQ-036 FALL_THROUGH=0, DEPTH=4, out_ready=0, push 0x01..0x05 -> first 4 accepted, in_ready=0 on 5th, count=4, almost_full=1 (AFULL_TH=3), hwm=4, then out_ready=1 pops 0x01,0x02,0x03,0x04 in order.
REQ-037 Push/pop continuously for 10 words with out_ready toggling every cycle -> output sequence identical to input, pointers wrap twice, no loss/duplication.
REQ-038 count=3, flush=1 with in_valid=1 -> in_ready=0 that cycle, count=0 next cycle, hwm retains 3, subsequent push 0x77 emerges first.
REQ-039 out_valid=1, out_ready=0 held 5 cycles -> stall_cnt=5, out_data stable; force stall_cnt near 0xFFFF_FFFE, stall 3 cycles -> saturates at 0xFFFF_FFFF.
REQ-040 rst_n pulsed low with count=2 -> all outputs at reset values immediately; after release, random push/pop traffic matches a reference queue model.
